// File: rtl/tdm_demux_8ch_if.sv
// Bus between a TDM word source and the 8-channel demultiplexer:
// the multiplexed input stream plus the per-channel outputs and framing status.
interface tdm_demux_8ch_if #(
  parameter int W = 4
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [2:0]   slot;
  logic         locked;
  logic         frame_valid;
  logic         sync_err;

  modport master (
    output din, din_valid, sync,
    input  o0, o1, o2, o3, o4, o5, o6, o7, slot, locked, frame_valid, sync_err
  );

  modport slave (
    input  din, din_valid, sync,
    output o0, o1, o2, o3, o4, o5, o6, o7, slot, locked, frame_valid, sync_err
  );
endinterface

// File: rtl/tdm_demux_8ch.sv
// 8-slot TDM demultiplexer: collects a frame in shadow registers and publishes
// all eight channels together on frame completion; re-hunts on a missing sync.
module tdm_demux_8ch #(
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst,
  tdm_demux_8ch_if.slave bus
);
  typedef enum logic {HUNT, LOCKED} state_t;

  state_t       state_reg;
  logic [2:0]   slot_reg;
  logic [W-1:0] sh_reg [0:6];
  logic [W-1:0] o_reg  [0:7];
  logic         frame_valid_reg;
  logic         sync_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= HUNT;
      slot_reg        <= 3'd0;
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
      for (int k = 0; k < 7; k++) sh_reg[k] <= '0;
      for (int k = 0; k < 8; k++) o_reg[k] <= '0;
    end else begin
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
      if (bus.din_valid) begin
        case (state_reg)
          HUNT: begin
            if (bus.sync) begin
              sh_reg[0] <= bus.din;
              slot_reg  <= 3'd1;
              state_reg <= LOCKED;
            end
          end
          LOCKED: begin
            if (slot_reg == 3'd0) begin
              if (bus.sync) begin
                sh_reg[0] <= bus.din;
                slot_reg  <= 3'd1;
              end else begin
                sync_err_reg <= 1'b1;
                slot_reg     <= 3'd0;
                state_reg    <= HUNT;
              end
            end else if (bus.sync) begin
              // Early sync restarts the frame; the partial frame is simply overwritten.
              sync_err_reg <= 1'b1;
              sh_reg[0]    <= bus.din;
              slot_reg     <= 3'd1;
            end else if (slot_reg == 3'd7) begin
              for (int k = 0; k < 7; k++) o_reg[k] <= sh_reg[k];
              o_reg[7]        <= bus.din;
              slot_reg        <= 3'd0;
              frame_valid_reg <= 1'b1;
            end else begin
              for (int k = 1; k < 7; k++) begin
                if (slot_reg == 3'(k)) sh_reg[k] <= bus.din;
              end
              slot_reg <= slot_reg + 3'd1;
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

  assign bus.o0          = o_reg[0];
  assign bus.o1          = o_reg[1];
  assign bus.o2          = o_reg[2];
  assign bus.o3          = o_reg[3];
  assign bus.o4          = o_reg[4];
  assign bus.o5          = o_reg[5];
  assign bus.o6          = o_reg[6];
  assign bus.o7          = o_reg[7];
  assign bus.slot        = slot_reg;
  assign bus.locked      = (state_reg == LOCKED);
  assign bus.frame_valid = frame_valid_reg;
  assign bus.sync_err    = sync_err_reg;
endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Scoreboard bench for tdm_demux_8ch: directed frames push expected pulses
// into queues; a negedge monitor pops and compares them with cycle timing.
module tb_tdm_demux_8ch;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int          at;
    logic [31:0] data;
  } frame_t;

  frame_t      fq[$];
  int          eq[$];
  logic [31:0] exp_o;

  tdm_demux_8ch_if #(.W(W)) bus ();

  tdm_demux_8ch #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] outs();
    return {bus.o7, bus.o6, bus.o5, bus.o4, bus.o3, bus.o2, bus.o1, bus.o0};
  endfunction

  // Monitor: every pulse must match the head of its queue at the expected cycle.
  always @(negedge clk) begin
    frame_t f;
    int     t;
    if (bus.frame_valid && bus.sync_err) begin
      checks++; errors++;
      $display("FAIL pulse_exclusive cyc=%0d got both pulses want at most one", cyc);
    end
    if (bus.frame_valid) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL frame_valid_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        f = fq.pop_front();
        if (f.at != cyc || outs() != f.data) begin
          errors++;
          $display("FAIL frame_out cyc=%0d got=%h want=%h at cyc %0d", cyc, outs(), f.data, f.at);
        end
      end
    end else if (fq.size() > 0 && fq[0].at <= cyc) begin
      checks++; errors++;
      $display("FAIL frame_valid_missing cyc=%0d got=0 want=1 (data %h)", cyc, fq[0].data);
      void'(fq.pop_front());
    end
    if (bus.sync_err) begin
      checks++;
      if (eq.size() == 0) begin
        errors++;
        $display("FAIL sync_err_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        t = eq.pop_front();
        if (t != cyc) begin
          errors++;
          $display("FAIL sync_err_timing got cyc=%0d want cyc=%0d", cyc, t);
        end
      end
    end else if (eq.size() > 0 && eq[0] <= cyc) begin
      checks++; errors++;
      $display("FAIL sync_err_missing cyc=%0d got=0 want=1", cyc);
      void'(eq.pop_front());
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end else begin
      $display("check %s = %h ok", name, got);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic word(input logic [3:0] d, input logic s, input bit fv, input bit er);
    frame_t f;
    bus.din = d; bus.sync = s; bus.din_valid = 1'b1;
    if (fv) begin
      f.at = cyc + 1; f.data = exp_o;
      fq.push_back(f);
    end
    if (er) eq.push_back(cyc + 1);
    $display("word din=%h sync=%0b exp_fv=%0b exp_err=%0b", d, s, fv, er);
    @(posedge clk);
    @(negedge clk);
    bus.din_valid = 1'b0; bus.sync = 1'b0;
  endtask

  task automatic idle(input int n, input logic [2:0] exp_slot);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("slot_during_gap", 32'(bus.slot), 32'(exp_slot));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    // Inputs that would start a frame must be overridden by reset.
    bus.din = 4'hA; bus.sync = 1'b1; bus.din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; bus.din_valid = 1'b0; bus.sync = 1'b0;
  endtask

  task automatic frame(input logic [31:0] vals);
    logic [31:0] v;
    v = vals;
    exp_o = vals;
    for (int k = 0; k < 8; k++) word(v[4*k +: 4], (k == 0), (k == 7), 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    bus.din = '0; bus.sync = 1'b0; bus.din_valid = 1'b0;
    @(negedge clk);
    do_reset();
    chk("reset_outs", outs(), 32'h0);
    chk("reset_slot", 32'(bus.slot), 32'd0);
    chk("reset_locked", 32'(bus.locked), 32'd0);
    chk("reset_pulses", {30'd0, bus.frame_valid, bus.sync_err}, 32'd0);

    // Frame 1..8
    frame(32'h87654321);
    chk("f1_outs", outs(), 32'h87654321);
    chk("f1_slot", 32'(bus.slot), 32'd0);
    chk("f1_locked", 32'(bus.locked), 32'd1);

    // No sync in HUNT: discarded
    do_reset();
    word(4'hF, 1'b0, 1'b0, 1'b0);
    word(4'hE, 1'b0, 1'b0, 1'b0);
    word(4'hD, 1'b0, 1'b0, 1'b0);
    chk("hunt_locked", 32'(bus.locked), 32'd0);
    chk("hunt_outs", outs(), 32'h0);
    chk("hunt_slot", 32'(bus.slot), 32'd0);
    frame(32'h76543210);
    chk("fa_outs", outs(), 32'h76543210);

    // Early sync at slot 4
    word(4'h5, 1'b1, 1'b0, 1'b0);
    word(4'h6, 1'b0, 1'b0, 1'b0);
    word(4'h7, 1'b0, 1'b0, 1'b0);
    word(4'h8, 1'b0, 1'b0, 1'b0);
    word(4'h9, 1'b1, 1'b0, 1'b1);
    chk("early_outs_hold", outs(), 32'h76543210);
    chk("early_slot", 32'(bus.slot), 32'd1);
    chk("early_locked", 32'(bus.locked), 32'd1);
    exp_o = 32'h76543219;
    a = exp_o;
    for (int k = 1; k < 8; k++) word(a[4*k +: 4], 1'b0, (k == 7), 1'b0);
    chk("early_next_outs", outs(), 32'h76543219);

    // Missing sync at slot 0
    word(4'h3, 1'b0, 1'b0, 1'b1);
    chk("miss_locked", 32'(bus.locked), 32'd0);
    chk("miss_outs_hold", outs(), 32'h76543219);
    chk("miss_slot", 32'(bus.slot), 32'd0);

    // Frame with idle gaps
    exp_o = 32'h0FEDCBA9;
    a = exp_o;
    for (int k = 0; k < 8; k++) begin
      idle($urandom_range(0, 3), 3'(k));
      word(a[4*k +: 4], (k == 0), (k == 7), 1'b0);
    end
    chk("gap_outs", outs(), 32'h0FEDCBA9);
    idle(2, 3'd0);

    // Reset after slot 5
    for (int k = 0; k < 6; k++) word(4'(k + 1), (k == 0), 1'b0, 1'b0);
    chk("pre_rst_slot", 32'(bus.slot), 32'd6);
    do_reset();
    chk("mid_rst_outs", outs(), 32'h0);
    chk("mid_rst_locked", 32'(bus.locked), 32'd0);
    chk("mid_rst_slot", 32'(bus.slot), 32'd0);
    frame(32'h01234567);
    chk("post_rst_outs", outs(), 32'h01234567);
    idle(3, 3'd0);

    chk("frame_queue_empty", 32'(fq.size()), 32'd0);
    chk("err_queue_empty", 32'(eq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tdm_demux_8ch.md
# tdm_demux_8ch

Receive-side counterpart of the 8:1 4-bit channel multiplexer. The block takes one time-division-multiplexed 4-bit word per valid cycle, where a frame is eight consecutive slots marked by a sync flag on slot 0. It distributes the words into eight channel registers. Outputs are double-buffered so all eight channels update together, once per completed frame.

## Interface

Parameters:

- W, 4, channel data width

Ports:

- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- din  input  W  multiplexed data word
- din_valid  input  1  din carries a slot word this cycle
- sync  input  1  qualifies din as slot 0 of a frame; ignored when din_valid=0
- o0..o7  output  W each  registered channel outputs; o<k> holds slot k of the last complete frame
- slot  output  3  slot index expected for the next valid word
- locked  output  1  1 while in LOCKED state
- frame_valid  output  1  one-cycle pulse: o0..o7 were updated on the preceding edge
- sync_err  output  1  one-cycle pulse: framing violation detected on the preceding edge

## Operation

- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Storage:
  - shadow registers sh0..sh6 (W bits each) collect a frame in progress;
  - output registers o0..o7 are loaded only on frame completion.
- States: HUNT and LOCKED. Reset state is HUNT.
- An accepted word is any cycle with din_valid=1. Cycles with din_valid=0 change nothing, except that both pulses return to 0.
- HUNT:
  - valid & ~sync: word discarded; remain in HUNT; no sync_err.
  - valid & sync: sh0<=din, slot<=1, go to LOCKED.
- LOCKED, slot=0:
  - valid & sync: sh0<=din, slot<=1.
  - valid & ~sync: missing sync. Pulse sync_err, discard the word, slot<=0, go to HUNT.
- LOCKED, slot=1..6:
  - valid & ~sync: sh[slot]<=din, slot<=slot+1.
  - valid & sync: early sync. Pulse sync_err, discard the partial frame, sh0<=din, slot<=1, stay LOCKED.
- LOCKED, slot=7:
  - valid & ~sync: frame complete. On the same edge, o0..o6<=sh0..sh6 and o7<=din; slot wraps to 0; frame_valid=1 for the next cycle.
  - valid & sync: same as the early-sync case (sync_err; word becomes slot 0 of a new frame; outputs unchanged).
- Outputs never show a mix of two frames. The o-registers change only on frame completion, all eight together.
- slot arithmetic is 3-bit. Increment from 7 wraps to 0 only on completion; all other paths assign slot explicitly.

## Timing

- Reset values (edge with rst=1): o0..o7=0, slot=0, state HUNT, locked=0, frame_valid=0, sync_err=0. Shadow registers=0.
- rst overrides all inputs in that cycle.
- Reset mid-frame discards the partial frame. Outputs clear to 0 and no pulse is produced.
- Latency: a slot-7 word accepted at edge N appears on o7 after edge N, together with frame_valid=1 in cycle N..N+1. Slots 0..6 reach the outputs at the same edge.
- frame_valid and sync_err are registered, single-cycle, and mutually exclusive.
- Back-to-back frames: a sync word can be accepted in the cycle right after slot 7, giving 8 valid cycles per frame with no gap. Valid gaps of any length are allowed between slots; slot holds its value during a gap.
- locked is the registered state, so it reflects transitions one cycle after the accepting edge.
- No backpressure: every valid word is consumed in its cycle.

## Test plan

- Reset, then one frame with din=1..8 on consecutive valid cycles, sync on the first word only:
  - o0..o7=1..8 one cycle after the eighth word;
  - frame_valid pulses once;
  - slot=0 and locked=1 afterwards.
- Valid words without sync after reset (din=F,E,D): state stays HUNT, outputs stay 0, no sync_err. A later sync frame 0..7 loads normally.
- Frame A=0..7 loaded, then a new frame with sync at slot 0 and a second sync at slot 4:
  - sync_err pulses at the second sync;
  - outputs still hold A;
  - the next frame, counted from the second sync, completes normally.
- After a completed frame, a valid word without sync at slot 0: sync_err pulses, locked drops to 0, outputs are retained.
- Frame with random din_valid gaps (0-3 idle cycles between slots), values 9,A,B,C,D,E,F,0: outputs correct, a single frame_valid, slot constant during gaps.
- rst asserted after slot 5 of a frame:
  - all outputs go to 0 and state is HUNT;
  - a subsequent full frame 7..0 loads correctly with no sync_err.
